// File: rtl/serial_addsub_n_if.sv
// Start/done operand and result bundle for the bit-serial adder/subtractor.
// The master drives the operands; the slave returns the result and status.
interface serial_addsub_n_if #(
  parameter int n = 4
);
  logic         start;
  logic         sub;
  logic [n-1:0] x;
  logic [n-1:0] y;
  logic [n-1:0] s;
  logic         cout;
  logic         overflow;
  logic         busy;
  logic         done;

  modport master (
    output start, sub, x, y,
    input  s, cout, overflow, busy, done
  );

  modport slave (
    input  start, sub, x, y,
    output s, cout, overflow, busy, done
  );
endinterface

// File: rtl/serial_addsub_n.sv
// Bit-serial n-bit adder/subtractor, LSB first, one bit per clock.
// Produces the result, carry-out (not-borrow on subtract) and overflow.
module serial_addsub_n #(
  parameter int n = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  serial_addsub_n_if.slave bus
);
  localparam int CW = $clog2(n + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [n-1:0]  r_a;
  logic [n-1:0]  r_b;
  logic [n-1:0]  r_s;
  logic          r_c;
  logic          r_cout;
  logic          r_ovf;
  logic [CW-1:0] r_cnt;
  logic          w_sum;
  logic          w_carry;
  logic          w_last;
  logic          w_load;

  assign w_sum   = r_a[0] ^ r_b[0] ^ r_c;
  assign w_carry = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);
  assign w_last  = (r_cnt == CW'(n - 1));

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_next = S_RUN;
          w_load = 1'b1;
        end
      end
      S_RUN: begin
        if (w_last) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_c     <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        // Subtract as X + ~Y + 1: invert B and seed the carry.
        r_a    <= bus.x;
        r_b    <= bus.sub ? ~bus.y : bus.y;
        r_c    <= bus.sub;
        r_cnt  <= '0;
        r_s    <= '0;
        r_cout <= 1'b0;
        r_ovf  <= 1'b0;
      end else if (r_state == S_RUN) begin
        r_s   <= {w_sum, r_s[n-1:1]};
        r_c   <= w_carry;
        r_a   <= r_a >> 1;
        r_b   <= r_b >> 1;
        r_cnt <= r_cnt + CW'(1);
        if (w_last) begin
          // r_c is still the carry into the MSB here.
          r_cout <= w_carry;
          r_ovf  <= w_carry ^ r_c;
        end
      end
    end
  end

  assign bus.s        = r_s;
  assign bus.cout     = r_cout;
  assign bus.overflow = r_ovf;
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.done     = (r_state == S_DONE);
endmodule

// File: doc/serial_addsub_n.md
Name: serial_addsub_n

Overview:
- Bit-serial n-bit adder/subtractor with a start/done handshake.
- Takes the same operand set as the combinational Addern (carry/mode, X, Y) and returns S, carry-out and overflow, one bit per clock, LSB first.
- Board-level Top wrappers drive it from SW/KEY and show results on LEDR.
- Serves as the sequential counterpart to Addern: trades area for n-cycle latency and adds subtraction.

Parameters:
- n, 4, operand and result width in bits (n >= 2).

Ports:
- Clock  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  request an operation; sampled only in IDLE.
- Sub  input  1  0 = X+Y, 1 = X−Y; sampled with Start.
- X  input  n  operand A; sampled with Start.
- Y  input  n  operand B; sampled with Start.
- S  output  n  result register.
- Cout  output  1  final carry-out. For Sub this is the not-borrow flag: 1 when X >= Y unsigned.
- Overflow  output  1  two's-complement overflow of the completed operation.
- Busy  output  1  high in RUN and DONE.
- Done  output  1  one-cycle pulse when S, Cout and Overflow become valid.

Behaviour:
- Reset (synchronous, Reset=1 at an edge):
  - state=IDLE; S=0, Cout=0, Overflow=0, Busy=0, Done=0.
  - Internal operand registers, carry and bit counter cleared.
- States:
  - IDLE: Busy=0, Done=0. Outputs hold the last result.
  - RUN: Busy=1, Done=0.
  - DONE: Busy=1, Done=1. Lasts exactly one cycle.
- IDLE→RUN, at an edge with Start=1 (call it edge T0):
  - A ← X.
  - B ← Sub ? ~Y : Y.
  - c ← Sub (two's-complement subtract).
  - count ← 0; S ← 0; Cout ← 0; Overflow ← 0.
- RUN, each edge Tk for k = 1..n processes bit i = k−1:
  - sum bit = A[0] ^ B[0] ^ c.
  - S shifts right, sum bit entering at S[n−1].
  - c ← majority(A[0], B[0], c).
  - A and B shift right; count increments.
  - At bit i = n−1, record the carry into the MSB (the c value before this edge's update) as cmsb.
- RUN→DONE at edge Tn:
  - S holds the full result.
  - Cout ← final carry.
  - Overflow ← final carry XOR cmsb.
- DONE→IDLE at edge Tn+1, unconditionally.
- Timing:
  - Done is high for exactly one cycle, n cycles after the loading edge.
  - Start-to-Done latency is n+1 edges counting T0.
  - Back-to-back operation: a Start held high re-launches at the first IDLE edge. Throughput is one operation per n+2 cycles.
- Start, Sub, X and Y are ignored while Busy=1. Operands are captured only at T0, so input changes mid-run have no effect.
- During RUN, S shows a partial shifted value and is not valid. S, Cout and Overflow are valid from the Done cycle until the next T0.
- Wrap-around: results are modulo 2^n, with carry/borrow reported only via Cout.
- Reset asserted in any state, including mid-RUN or in DONE, overrides everything. It returns to IDLE with all outputs 0 at that edge, and no Done pulse is produced. Reset together with Start: Reset wins.
- Width: count is ceil(log2(n+1)) bits. No other arithmetic is wider than n bits plus the carry.

Test Plan (n=4):
- Reset then Start with Sub=0, X=0011, Y=0101 → Done pulses 4 cycles after the load edge; S=1000, Cout=0, Overflow=1.
- Sub=0, X=1001, Y=0111 → S=0000, Cout=1, Overflow=0.
- Sub=1, X=0101, Y=0011 → S=0010, Cout=1, Overflow=0. Then Sub=1, X=0011, Y=0101 → S=1110, Cout=0, Overflow=0.
- Sub=1, X=1000, Y=0001 → S=0111, Cout=1, Overflow=1.
- Start pulsed and X/Y toggled during RUN:
  - no relaunch; result matches the operands captured at T0.
  - Done is high for exactly one cycle; Busy covers exactly 5 cycles.
  - Start held high continuously → successive Done pulses exactly 6 cycles apart.
- Reset asserted at the 2nd RUN edge → next cycle state=IDLE, S=0, Cout=0, Overflow=0, Busy=0; no Done pulse. A following Start completes normally.
